// File: rtl/nios0_gpio_irq_if.sv
// nios0_gpio_irq_if
//   Avalon-MM slave bus bundle for the nios0 GPIO/IRQ peripheral.
//
//   Signals:
//     address    3-bit word register select      (master -> slave)
//     chipselect slave select                    (master -> slave)
//     write_n    active-low write strobe         (master -> slave)
//     writedata  32-bit write data               (master -> slave)
//     readdata   32-bit registered read data     (slave  -> master)
//
//   Modports:
//     master  drives the request side, samples readdata
//     slave   samples the request side, drives readdata

interface nios0_gpio_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios0_gpio_irq.sv
// nios0_gpio_irq
//   Parametrised Avalon-MM general-purpose I/O slave with per-bit direction,
//   2-flop input synchronisers, per-bit edge capture and a maskable level
//   interrupt for the Nios II.
//
//   Parameters:
//     WIDTH      port width in bits (1..32)
//     RESET_OUT  reset value of the data_out register
//     RESET_DIR  reset value of the direction register (1 = drive pad)
//     EDGE_TYPE  capture mode: 0 rising, 1 falling, 2 any edge (3 acts as 0)
//
//   Ports:
//     clk       system clock
//     reset     asynchronous active-high reset
//     bus       Avalon-MM slave (address, chipselect, write_n, writedata,
//               readdata); readdata is registered, 1-cycle latency
//     in_port   external inputs, asynchronous to clk
//     out_port  data_out register
//     out_oe    direction register
//     irq       level interrupt, |(edgecapture & irqmask)
//
//   Register map (word addresses):
//     0 data        read: synchronised in_port, write: data_out
//     1 direction   R/W
//     2 irqmask     R/W
//     3 edgecapture read: captured bits, write: 1 clears that bit
//     4 outset      data_out |= wdata   (NIOS0_GPIO_OUTSETCLR_EN), reads 0
//     5 outclear    data_out &= ~wdata  (NIOS0_GPIO_OUTSETCLR_EN), reads 0
//     6,7           reserved, read 0, writes ignored
//
//   Build option:
//     NIOS0_GPIO_OUTSETCLR_EN  enables the outset/outclear registers. Without
//     it addresses 4 and 5 are reserved like 6 and 7.

module nios0_gpio_irq #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0,
    parameter int               EDGE_TYPE = 0
) (
    input  logic              clk,
    input  logic              reset,
    nios0_gpio_irq_if.slave   bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  out_oe,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
`ifdef NIOS0_GPIO_OUTSETCLR_EN
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`endif

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_out_reg,    data_out_next;
    logic [WIDTH-1:0] dir_reg,         dir_next;
    logic [WIDTH-1:0] irqmask_reg,     irqmask_next;
    logic [WIDTH-1:0] edgecapture_reg, edgecapture_next;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [31:0]      readdata_reg,    readdata_next;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic             edge_clr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] detect;

    assign wr_en       = bus.chipselect & ~bus.write_n;
    assign edge_clr_en = wr_en && (bus.address == ADDR_EDGE);
    assign wr_data     = bus.writedata[WIDTH-1:0];

    // Upper write-data bits beyond WIDTH carry no meaning for this block.
    logic unused_wdata;
    assign unused_wdata = ^{1'b0, bus.writedata};

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit edge detect and capture. Detection ignores out_oe, so an
    // output-configured bit still captures its own pad loopback. A new edge
    // on the same cycle as a software clear keeps the bit set, so no event
    // is lost between the ISR reading and clearing edgecapture.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 1) begin : g_fall
                assign detect[gi] = ~sync2_reg[gi] & prev_reg[gi];
            end else if (EDGE_TYPE == 2) begin : g_any
                assign detect[gi] = sync2_reg[gi] ^ prev_reg[gi];
            end else begin : g_rise
                // EDGE_TYPE 0 and the unused encoding 3 both capture rising.
                assign detect[gi] = sync2_reg[gi] & ~prev_reg[gi];
            end

            assign edgecapture_next[gi] = detect[gi]
                | (edgecapture_reg[gi] & ~(edge_clr_en & wr_data[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Writable register next-state
    // ------------------------------------------------------------------
    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        irqmask_next  = irqmask_reg;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   data_out_next = wr_data;
                ADDR_DIR:    dir_next      = wr_data;
                ADDR_MASK:   irqmask_next  = wr_data;
`ifdef NIOS0_GPIO_OUTSETCLR_EN
                // Atomic set/clear lets several tasks own different bits
                // without a read-modify-write race.
                ADDR_OUTSET: data_out_next = data_out_reg | wr_data;
                ADDR_OUTCLR: data_out_next = data_out_reg & ~wr_data;
`endif
                default:     ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux: registered every cycle regardless of the strobes; reads
    // have no side effects. Bits above WIDTH stay zero.
    // ------------------------------------------------------------------
    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = sync2_reg;
            ADDR_DIR:  readdata_next[WIDTH-1:0] = dir_reg;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edgecapture_reg;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_reg    <= RESET_OUT;
            dir_reg         <= RESET_DIR;
            irqmask_reg     <= '0;
            edgecapture_reg <= '0;
            readdata_reg    <= '0;
        end else begin
            data_out_reg    <= data_out_next;
            dir_reg         <= dir_next;
            irqmask_reg     <= irqmask_next;
            edgecapture_reg <= edgecapture_next;
            readdata_reg    <= readdata_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. irq is combinational from registers so it follows a capture
    // or an irqmask write in the very next cycle.
    // ------------------------------------------------------------------
    assign out_port     = data_out_reg;
    assign out_oe       = dir_reg;
    assign irq          = |(edgecapture_reg & irqmask_reg);
    assign bus.readdata = readdata_reg;

endmodule

// File: tb/tb_nios0_gpio_irq.sv
// tb_nios0_gpio_irq
//   Directed bench for nios0_gpio_irq. Two instances share clk/reset:
//   u_dut0 with EDGE_TYPE=0 and u_dut1 with EDGE_TYPE=2, both WIDTH=8,
//   RESET_OUT=8'hA5, RESET_DIR=8'h0F. Inputs are driven and outputs sampled
//   on the falling clock edge; every task starts and ends on a falling edge.

module tb_nios0_gpio_irq;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_port0, in_port1;
    logic [7:0] out_port0, out_port1;
    logic [7:0] out_oe0, out_oe1;
    logic       irq0, irq1;

    int checks   = 0;
    int failures = 0;

    nios0_gpio_irq_if bif0 ();
    nios0_gpio_irq_if bif1 ();

    always #5 clk = ~clk;

    nios0_gpio_irq #(
        .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(bif0.slave),
        .in_port(in_port0), .out_port(out_port0), .out_oe(out_oe0), .irq(irq0)
    );

    nios0_gpio_irq #(
        .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .bus(bif1.slave),
        .in_port(in_port1), .out_port(out_port1), .out_oe(out_oe1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input int sel, input logic [2:0] a,
                             input logic [31:0] d);
        if (sel == 0) begin
            bif0.address = a; bif0.writedata = d;
            bif0.chipselect = 1'b1; bif0.write_n = 1'b0;
        end else begin
            bif1.address = a; bif1.writedata = d;
            bif1.chipselect = 1'b1; bif1.write_n = 1'b0;
        end
        @(negedge clk);
        bif0.chipselect = 1'b0; bif0.write_n = 1'b1;
        bif1.chipselect = 1'b0; bif1.write_n = 1'b1;
        $display("write dut%0d addr=%0d data=%h", sel, a, d);
    endtask

    task automatic bus_read(input int sel, input logic [2:0] a,
                            output logic [31:0] d);
        if (sel == 0) begin
            bif0.address = a; bif0.chipselect = 1'b1;
        end else begin
            bif1.address = a; bif1.chipselect = 1'b1;
        end
        @(negedge clk);
        d = (sel == 0) ? bif0.readdata : bif1.readdata;
        bif0.chipselect = 1'b0;
        bif1.chipselect = 1'b0;
        $display("read  dut%0d addr=%0d data=%h", sel, a, d);
    endtask

    logic [31:0] rd;
    logic [7:0]  exp_set, exp_clr;

    initial begin
`ifdef NIOS0_GPIO_OUTSETCLR_EN
        exp_set = 8'h3F;
        exp_clr = 8'h0F;
`else
        exp_set = 8'h3C;
        exp_clr = 8'h3C;
`endif
        reset = 1'b1;
        in_port0 = 8'h00;
        in_port1 = 8'h00;
        bif0.address = 3'd0; bif0.chipselect = 1'b0; bif0.write_n = 1'b1;
        bif0.writedata = 32'h0;
        bif1.address = 3'd0; bif1.chipselect = 1'b0; bif1.write_n = 1'b1;
        bif1.writedata = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_out_port", {24'h0, out_port0}, 32'hA5);
        check("rst_out_oe",   {24'h0, out_oe0},   32'h0F);
        check("rst_irq",      {31'h0, irq0},      32'h0);
        check("rst_readdata", bif0.readdata,      32'h0);
        reset = 1'b0;
        bus_read(0, 3'd3, rd);
        check("rst_edgecap", rd, 32'h0);

        // Data and direction registers
        bus_write(0, 3'd0, 32'h0000_013C);
        check("data_out_write", {24'h0, out_port0}, 32'h3C);
        bus_read(0, 3'd1, rd);
        check("dir_read_reset", rd, 32'h0000_000F);
        bus_write(0, 3'd1, 32'h0000_01FF);
        check("dir_out_oe", {24'h0, out_oe0}, 32'hFF);
        bus_read(0, 3'd1, rd);
        check("dir_read_upper0", rd, 32'h0000_00FF);

        // Rising capture on bit2: lands on the 3rd edge after the change
        bus_write(0, 3'd2, 32'h04);
        in_port0 = 8'h04;
        tick();
        check("cap_edge1_irq", {31'h0, irq0}, 32'h0);
        tick();
        check("cap_edge2_irq", {31'h0, irq0}, 32'h0);
        tick();
        check("cap_edge3_irq", {31'h0, irq0}, 32'h1);
        bus_read(0, 3'd3, rd);
        check("cap_edgecap", rd, 32'h04);
        bus_read(0, 3'd0, rd);
        check("data_read_sync", rd, 32'h04);
        bus_write(0, 3'd3, 32'h04);
        check("w1c_irq", {31'h0, irq0}, 32'h0);
        bus_read(0, 3'd3, rd);
        check("w1c_edgecap", rd, 32'h0);

        // Falling edge ignored in rising mode; then edge vs. clear collision
        in_port0 = 8'h00;
        repeat (4) tick();
        check("fall_ignored_irq", {31'h0, irq0}, 32'h0);
        in_port0 = 8'h04;
        tick();
        tick();
        bus_write(0, 3'd3, 32'h04);
        check("set_wins_irq", {31'h0, irq0}, 32'h1);
        bus_read(0, 3'd3, rd);
        check("set_wins_edgecap", rd, 32'h04);

        // Any-edge instance, bit0 pulse 1->0->1 with irqmask=0
        in_port1 = 8'h01;
        repeat (4) tick();
        bus_write(1, 3'd3, 32'hFF);
        in_port1 = 8'h00;
        repeat (4) tick();
        bus_read(1, 3'd3, rd);
        check("any_fall_cap", rd, 32'h01);
        bus_write(1, 3'd3, 32'hFF);
        in_port1 = 8'h01;
        repeat (4) tick();
        bus_read(1, 3'd3, rd);
        check("any_rise_cap", rd, 32'h01);
        check("any_masked_irq", {31'h0, irq1}, 32'h0);
        bus_write(1, 3'd2, 32'h01);
        check("any_unmask_irq", {31'h0, irq1}, 32'h1);

        // Outset / outclear and reserved addresses
        bus_write(0, 3'd4, 32'h03);
        check("outset", {24'h0, out_port0}, {24'h0, exp_set});
        bus_write(0, 3'd5, 32'h30);
        check("outclear", {24'h0, out_port0}, {24'h0, exp_clr});
        bus_read(0, 3'd4, rd);
        check("read_addr4", rd, 32'h0);
        bus_read(0, 3'd5, rd);
        check("read_addr5", rd, 32'h0);
        bus_write(0, 3'd7, 32'hFF);
        check("reserved_wr", {24'h0, out_port0}, {24'h0, exp_clr});
        bus_read(0, 3'd7, rd);
        check("read_addr7", rd, 32'h0);
        bus_read(0, 3'd2, rd);
        check("irqmask_read", rd, 32'h04);

        // Reset mid-operation drops pending captures
        reset = 1'b1;
        tick();
        check("midrst_irq1", {31'h0, irq1}, 32'h0);
        check("midrst_out_port", {24'h0, out_port0}, 32'hA5);
        reset = 1'b0;
        bus_read(1, 3'd3, rd);
        check("midrst_edgecap", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
